clk_sel_ctrl: RTL

Control stage directly upstream of the 2:1 glitch-free clock switch. It produces the registered, clk0-domain select that drives the switch's io_clksel input.
- Accepts a software request for clk1 and confirms clk1 is actually toggling via a frequency-presence monitor.
- Enforces a minimum dwell time between switchovers.
- Forces fallback to clk0, with a sticky fault flag, if clk1 dies while selected.

---
 rtl/clk_sw_pkg.sv | 25 ++
 rtl/clk_alive_mon.sv | 96 +++++++++
 rtl/clk_sel_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/clk_sw_pkg.sv
// Shared types and default constants for the clk0/clk1 select controller.
package clk_sw_pkg;

    // Select FSM states: SEL0 and WAIT1 drive clk0, SEL1 drives clk1.
    typedef enum logic [1:0] {
        SEL0  = 2'd0,
        WAIT1 = 2'd1,
        SEL1  = 2'd2
    } sel_state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DIV_W_DEF       = 3;
    localparam int WIN_LEN_DEF     = 16;
    localparam int MIN_EDGES_DEF   = 4;
    localparam int DWELL_DEF       = 32;

    localparam int WIN_W   = $clog2(WIN_LEN_DEF);
    localparam int DWELL_W = $clog2(DWELL_DEF);

    // Counter width for a count range of 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_alive_mon.sv
// clk1 presence monitor: a clk1-domain divider whose MSB is synchronized
// into clk0, edge-detected and counted over fixed windows. The verdict is
// refreshed once per window.
module clk_alive_mon
    import clk_sw_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int WIN_LEN     = WIN_LEN_DEF,
    parameter int MIN_EDGES   = MIN_EDGES_DEF
) (
    input  logic clk0,
    input  logic rst,
    input  logic clk1,
    output logic clk1_alive
);

    localparam int WIN_W_L = cnt_width(WIN_LEN);
    localparam int EDGE_W  = cnt_width(MIN_EDGES + 1);
    localparam logic [WIN_W_L-1:0] WIN_LAST = WIN_W_L'(WIN_LEN - 1);
    localparam logic [EDGE_W-1:0]  EDGE_MAX = EDGE_W'(MIN_EDGES);

    // ---------------- clk1 domain ----------------
    logic [1:0]       rst1_q, rst1_d;
    logic [DIV_W-1:0] div_q, div_d;

    // Resample rst into clk1 and free-run the divider once it is released.
    always_comb begin
        rst1_d = {rst1_q[0], rst};
        div_d  = rst1_q[1] ? '0 : div_q + DIV_W'(1);
    end

    // clk1-domain registers.
    always_ff @(posedge clk1) begin
        rst1_q <= rst1_d;
        div_q  <= div_d;
    end

    // ---------------- clk0 domain ----------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [WIN_W_L-1:0]     win_cnt_q, win_cnt_d;
    logic [EDGE_W-1:0]      edge_cnt_q, edge_cnt_d;
    logic                   alive_q, alive_d;
    logic                   pulse;
    logic                   win_last;
    logic [EDGE_W:0]        edge_sum;

    // Synchronizer chain: stage 0 samples the divider MSB, later stages shift.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = rst ? 1'b0 : div_q[DIV_W-1];
            end else begin : g_rest
                assign sync_d[gi] = rst ? 1'b0 : sync_q[gi-1];
            end
        end
    endgenerate

    assign pulse    = sync_q[SYNC_STAGES-1] ^ prev_q;
    assign win_last = (win_cnt_q == WIN_LAST);
    assign edge_sum = {1'b0, edge_cnt_q} + {{EDGE_W{1'b0}}, pulse};

    // Edge counting per window; the last window cycle also counts its own pulse.
    always_comb begin
        prev_d     = sync_q[SYNC_STAGES-1];
        win_cnt_d  = win_cnt_q + WIN_W_L'(1);
        edge_cnt_d = edge_cnt_q;
        alive_d    = alive_q;
        if (win_last) begin
            win_cnt_d  = '0;
            edge_cnt_d = '0;
            alive_d    = (edge_sum >= {1'b0, EDGE_MAX});
        end else if (pulse && (edge_cnt_q != EDGE_MAX)) begin
            edge_cnt_d = edge_cnt_q + EDGE_W'(1);
        end
        if (rst) begin
            prev_d     = 1'b0;
            win_cnt_d  = '0;
            edge_cnt_d = '0;
            alive_d    = 1'b0;
        end
    end

    // clk0-domain monitor registers.
    always_ff @(posedge clk0) begin
        sync_q     <= sync_d;
        prev_q     <= prev_d;
        win_cnt_q  <= win_cnt_d;
        edge_cnt_q <= edge_cnt_d;
        alive_q    <= alive_d;
    end

    assign clk1_alive = alive_q;

endmodule

// File: rtl/clk_sel_ctrl.sv
// Registered select generator for the glitch-free clk0/clk1 switch: request
// handshake through WAIT1, dwell enforcement on voluntary switches, forced
// fallback with a sticky fault when clk1 disappears.
module clk_sel_ctrl
    import clk_sw_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int WIN_LEN     = WIN_LEN_DEF,
    parameter int MIN_EDGES   = MIN_EDGES_DEF,
    parameter int DWELL       = DWELL_DEF
) (
    input  logic       clk0,
    input  logic       rst,
    input  logic       clk1,
    input  logic       req_sel,
    input  logic       fault_clr,
    output logic       clk_sel,
    output logic       clk1_alive,
    output logic       busy,
    output logic       fault,
    output logic [7:0] switch_cnt
);

    localparam int DWELL_W_L = cnt_width(DWELL);
    localparam logic [DWELL_W_L-1:0] DWELL_LOAD = DWELL_W_L'(DWELL - 1);

    sel_state_t           state_q, state_d;
    logic [DWELL_W_L-1:0] dwell_q, dwell_d;
    logic                 clk_sel_q, clk_sel_d;
    logic                 busy_q, busy_d;
    logic                 fault_q, fault_d;
    logic [7:0]           switch_cnt_q, switch_cnt_d;
    logic                 dwell_done;
    logic                 change;
    logic                 alive;

    clk_alive_mon #(
        .SYNC_STAGES (SYNC_STAGES),
        .DIV_W       (DIV_W),
        .WIN_LEN     (WIN_LEN),
        .MIN_EDGES   (MIN_EDGES)
    ) u_mon (
        .clk0       (clk0),
        .rst        (rst),
        .clk1       (clk1),
        .clk1_alive (alive)
    );

    assign dwell_done = (dwell_q == '0);

    // Next-state, dwell, fault and counter logic; loss of clk1 preempts all.
    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_done ? dwell_q : dwell_q - DWELL_W_L'(1);
        fault_d      = fault_q;
        switch_cnt_d = switch_cnt_q;
        change       = 1'b0;

        if (fault_clr) begin
            fault_d = 1'b0;
        end

        case (state_q)
            SEL0: begin
                if (req_sel && dwell_done) begin
                    state_d = WAIT1;
                end
            end
            WAIT1: begin
                if (!req_sel) begin
                    state_d = SEL0;
                end else if (alive) begin
                    state_d = SEL1;
                    change  = 1'b1;
                end
            end
            SEL1: begin
                if (!alive) begin
                    state_d = SEL0;
                    fault_d = 1'b1;
                    change  = 1'b1;
                end else if (!req_sel && dwell_done) begin
                    state_d = SEL0;
                    change  = 1'b1;
                end
            end
            default: begin
                state_d = SEL0;
            end
        endcase

        if (change) begin
            dwell_d      = DWELL_LOAD;
            switch_cnt_d = switch_cnt_q + 8'd1;
        end

        clk_sel_d = (state_d == SEL1);
        busy_d    = (dwell_d != '0) || (state_d == WAIT1);

        if (rst) begin
            state_d      = SEL0;
            dwell_d      = '0;
            fault_d      = 1'b0;
            switch_cnt_d = 8'd0;
            clk_sel_d    = 1'b0;
            busy_d       = 1'b0;
        end
    end

    // Controller registers; all outputs come straight from these.
    always_ff @(posedge clk0) begin
        state_q      <= state_d;
        dwell_q      <= dwell_d;
        clk_sel_q    <= clk_sel_d;
        busy_q       <= busy_d;
        fault_q      <= fault_d;
        switch_cnt_q <= switch_cnt_d;
    end

    assign clk_sel    = clk_sel_q;
    assign clk1_alive = alive;
    assign busy       = busy_q;
    assign fault      = fault_q;
    assign switch_cnt = switch_cnt_q;

endmodule
